adc_spi_responder: RTL and testbench

- Synthesizable SPI responder that emulates an 8-channel, 12-bit ADC of the ADC128S type.
- It is the far end of the IR sensor SPI master. Used in FPGA bring-up and in benches in place of the behavioural ADC model.
- All logic runs on the system clock. SS_n, SCLK and MOSI are oversampled.
- Returns deterministic, channel-tagged conversion values so the master's readings can be checked exactly.

---
 rtl/adc_spi_responder_if.sv | 11 +
 rtl/adc_spi_responder.sv | 123 ++++++++++++
 tb/tb_adc_spi_responder.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/adc_spi_responder_if.sv
// adc_spi_responder_if: SPI bus between a master and the ADC responder.
// The master modport drives select, clock and command; the slave modport returns MISO.
interface adc_spi_responder_if;
   logic SS_n;
   logic SCLK;
   logic MOSI;
   logic MISO;

   modport master (output SS_n, output SCLK, output MOSI, input MISO);
   modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/adc_spi_responder.sv
// adc_spi_responder: 8-channel 12-bit ADC128S-style SPI responder, oversampled on clk.
// Define ADC_MISO_TRISTATE_EN to release MISO (1'bz) whenever no frame is being shifted.
module adc_spi_responder #(
   parameter logic [11:0] RESET_VAL   = 12'hC00,
   parameter logic [11:0] STEP        = 12'h010,
   parameter int          SYNC_STAGES = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   adc_spi_responder_if.slave        spi,
   output logic                      frame_done,
   output logic                      frame_err,
   output logic [2:0]                cur_ch
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] ss_sync;
   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   ss_prev;
   logic                   sclk_prev;
   logic                   ss_s;
   logic                   sclk_s;
   logic                   mosi_s;
   logic                   ss_fall;
   logic                   ss_rise;
   logic                   sclk_rise;
   logic                   sclk_fall;
   logic [11:0]            cnt;
   logic [11:0]            result;
   logic [4:0]             bit_cnt;
   logic [15:0]            tx_shift;
   logic [13:0]            rx_shift;

   assign ss_s      = ss_sync[SYNC_STAGES-1];
   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign ss_fall   = ss_prev & ~ss_s;
   assign ss_rise   = ~ss_prev & ss_s;
   assign sclk_rise = ~sclk_prev & sclk_s;
   assign sclk_fall = sclk_prev & ~sclk_s;
   assign result    = {cnt[11:4], 1'b0, cur_ch};

   // Resync chains reset to the bus idle levels so no edge is seen on reset release
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ss_sync   <= '1;
         sclk_sync <= '0;
         mosi_sync <= '0;
         ss_prev   <= 1'b1;
         sclk_prev <= 1'b0;
      end else begin
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi.SS_n};
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.SCLK};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.MOSI};
         ss_prev   <= ss_s;
         sclk_prev <= sclk_s;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= RESET_VAL;
         cur_ch     <= '0;
         bit_cnt    <= '0;
         tx_shift   <= '0;
         rx_shift   <= '0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (ss_fall) begin
                  state    <= SHIFT;
                  tx_shift <= {4'b0000, result};
                  bit_cnt  <= '0;
               end
            end
            SHIFT: begin
               if (ss_rise) begin
                  tx_shift <= '0;
                  if (bit_cnt == 5'd16) begin
                     state <= DONE;
                  end else begin
                     state     <= IDLE;
                     frame_err <= 1'b1;
                  end
               end else if (bit_cnt != 5'd16) begin
                  // The 16th rise clears tx_shift so MISO holds 0 until the frame closes
                  if (sclk_rise) begin
                     rx_shift <= {rx_shift[12:0], mosi_s};
                     bit_cnt  <= bit_cnt + 5'd1;
                     if (bit_cnt == 5'd15) begin
                        tx_shift <= '0;
                     end
                  end else if (sclk_fall) begin
                     tx_shift <= {tx_shift[14:0], 1'b0};
                  end
               end
            end
            DONE: begin
               cur_ch     <= rx_shift[13:11];
               cnt        <= cnt - STEP;
               frame_done <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ADC_MISO_TRISTATE_EN
   assign spi.MISO = (state == SHIFT) ? tx_shift[15] : 1'bz;
`else
   assign spi.MISO = (state == SHIFT) ? tx_shift[15] : 1'b0;
`endif

endmodule

// File: tb/tb_adc_spi_responder.sv
// tb_adc_spi_responder: directed bench acting as SPI master for adc_spi_responder.
// Frame vectors come from a table; wrap-around and mid-frame reset are hand-written sequences.
module tb_adc_spi_responder;

   localparam int SYNC = 2;

`ifdef ADC_MISO_TRISTATE_EN
   localparam logic [15:0] IDLE_MISO = {15'b0, 1'bz};
`else
   localparam logic [15:0] IDLE_MISO = 16'h0000;
`endif

   typedef struct {
      logic [15:0] cmd;
      int          nbits;
      logic [15:0] exp_rx;
      int          exp_done;
      int          exp_err;
      logic [2:0]  exp_ch;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       frame_done;
   logic       frame_err;
   logic [2:0] cur_ch;

   int tests_run    = 0;
   int tests_failed = 0;
   int done_pulses  = 0;
   int err_pulses   = 0;

   vec_t vecs [11];

   adc_spi_responder_if spi_bus ();

   adc_spi_responder #(
      .RESET_VAL   (12'hC00),
      .STEP        (12'h010),
      .SYNC_STAGES (SYNC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .spi        (spi_bus),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .cur_ch     (cur_ch)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_done === 1'b1) done_pulses++;
      if (frame_err === 1'b1)  err_pulses++;
   end

   task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      spi_bus.SS_n = 1'b1;
      spi_bus.SCLK = 1'b0;
      spi_bus.MOSI = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   // One SCLK period: MISO is captured just before the rising edge, as a mode-0 master does
   task automatic spi_bit(input logic mosi, output logic miso);
      spi_bus.MOSI = mosi;
      repeat (4) @(negedge clk);
      miso = spi_bus.MISO;
      spi_bus.SCLK = 1'b1;
      repeat (8) @(negedge clk);
      spi_bus.SCLK = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic apply_stimulus(input logic [15:0] cmd, input int nbits,
                                 output logic [15:0] rx, output logic miso_tail);
      logic b;
      rx = '0;
      spi_bus.SS_n = 1'b0;
      repeat (SYNC + 1) @(negedge clk);
      check_output("miso_driven_after_ss_fall", {15'b0, spi_bus.MISO}, 16'h0000);
      repeat (5) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         spi_bit(cmd[15-i], b);
         rx[15-i] = b;
      end
      repeat (4) @(negedge clk);
      miso_tail    = spi_bus.MISO;
      spi_bus.SS_n = 1'b1;
      spi_bus.MOSI = 1'b0;
      repeat (SYNC + 4) @(negedge clk);
   endtask

   initial begin
      logic [15:0] rx;
      logic [15:0] mask;
      logic        tail;
      logic        b;
      logic [11:0] model_cnt;
      logic [2:0]  model_ch;
      int          d0;
      int          e0;

      vecs[0]  = '{16'h0800, 16, 16'h0C00, 1, 0, 3'd1};
      vecs[1]  = '{16'h1000, 16, 16'h0BF1, 1, 0, 3'd2};
      vecs[2]  = '{16'h1800, 16, 16'h0BE2, 1, 0, 3'd3};
      vecs[3]  = '{16'h2000, 16, 16'h0BD3, 1, 0, 3'd4};
      vecs[4]  = '{16'h2800, 16, 16'h0BC4, 1, 0, 3'd5};
      vecs[5]  = '{16'h3000, 16, 16'h0BB5, 1, 0, 3'd6};
      vecs[6]  = '{16'h3800, 16, 16'h0BA6, 1, 0, 3'd7};
      vecs[7]  = '{16'hC7FF, 16, 16'h0B97, 1, 0, 3'd0};
      vecs[8]  = '{16'h1800,  9, 16'h0B80, 0, 1, 3'd0};
      vecs[9]  = '{16'h1000, 16, 16'h0B80, 1, 0, 3'd2};
      vecs[10] = '{16'h2800, 16, 16'h0B72, 1, 0, 3'd5};

      do_reset();
      check_output("reset_miso",       {15'b0, spi_bus.MISO}, IDLE_MISO);
      check_output("reset_frame_done", {15'b0, frame_done},   16'h0000);
      check_output("reset_frame_err",  {15'b0, frame_err},    16'h0000);
      check_output("reset_cur_ch",     {13'b0, cur_ch},       16'h0000);

      for (int k = 0; k < 11; k++) begin
         d0 = done_pulses;
         e0 = err_pulses;
         apply_stimulus(vecs[k].cmd, vecs[k].nbits, rx, tail);
         mask = 16'hFFFF << (16 - vecs[k].nbits);
         check_output($sformatf("vec%0d_rx", k),     rx, vecs[k].exp_rx & mask);
         check_output($sformatf("vec%0d_done", k),   16'(done_pulses - d0), 16'(vecs[k].exp_done));
         check_output($sformatf("vec%0d_err", k),    16'(err_pulses - e0),  16'(vecs[k].exp_err));
         check_output($sformatf("vec%0d_cur_ch", k), {13'b0, cur_ch}, {13'b0, vecs[k].exp_ch});
         if (vecs[k].nbits == 16)
            check_output($sformatf("vec%0d_miso_tail", k), {15'b0, tail}, 16'h0000);
         check_output($sformatf("vec%0d_idle_miso", k), {15'b0, spi_bus.MISO}, IDLE_MISO);
      end

      // Counter wrap: 192 frames bring cnt from C00 down to 000
      do_reset();
      model_cnt = 12'hC00;
      model_ch  = 3'd0;
      d0 = done_pulses;
      for (int k = 0; k < 192; k++) begin
         apply_stimulus(16'h0000, 16, rx, tail);
         check_output($sformatf("wrap_frame%0d_rx", k + 1), rx, {4'b0, model_cnt[11:4], 1'b0, model_ch});
         model_cnt = model_cnt - 12'h010;
      end
      check_output("wrap_done_count", 16'(done_pulses - d0), 16'd192);
      apply_stimulus(16'h2000, 16, rx, tail);
      check_output("frame193_rx", rx, 16'h0000);
      check_output("frame193_cur_ch", {13'b0, cur_ch}, 16'h0004);
      apply_stimulus(16'h3000, 16, rx, tail);
      check_output("frame194_rx", rx, 16'h0FF4);
      check_output("frame194_cur_ch", {13'b0, cur_ch}, 16'h0006);

      // Reset in the middle of a frame returning 0FE6, while MISO is high
      spi_bus.SS_n = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < 7; i++) spi_bit(1'b0, b);
      check_output("pre_reset_miso", {15'b0, spi_bus.MISO}, 16'h0001);
      rst = 1'b1;
      #1;
      check_output("midframe_reset_miso",   {15'b0, spi_bus.MISO}, IDLE_MISO);
      check_output("midframe_reset_cur_ch", {13'b0, cur_ch},       16'h0000);
      spi_bus.SS_n = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      d0 = done_pulses;
      e0 = err_pulses;
      apply_stimulus(16'h0000, 16, rx, tail);
      check_output("post_reset_rx",   rx, 16'h0C00);
      check_output("post_reset_done", 16'(done_pulses - d0), 16'd1);
      check_output("post_reset_err",  16'(err_pulses - e0),  16'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
